// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the 4-bit-op 32-bit ALU: decodes MIPS32 words into
// registered ALU operands (S1), then captures result and flags into a writeback register (S2).
module alu_issue_ctrl #(
    parameter bit TRAP_ON_OVERFLOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [3:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    input  logic        alu_zero,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic [3:0]  wb_flags,
    output logic        wb_illegal,
    output logic        wb_ovf_trap
);

    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_XOR  = 4'h2;
    localparam logic [3:0] OP_NOR  = 4'h3;
    localparam logic [3:0] OP_ADDU = 4'h4;
    localparam logic [3:0] OP_SUBU = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_SLLV = 4'h9;
    localparam logic [3:0] OP_SRLV = 4'hB;
    localparam logic [3:0] OP_SLT  = 4'hC;
    localparam logic [3:0] OP_SLTU = 4'hD;
    localparam logic [3:0] OP_CLO  = 4'hE;
    localparam logic [3:0] OP_CLZ  = 4'hF;

    localparam logic [5:0] OPC_SPECIAL  = 6'h00;
    localparam logic [5:0] OPC_SPECIAL2 = 6'h1C;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt_f;
    logic [4:0]  rd_f;
    logic [4:0]  shamt;
    logic [31:0] imm_s;
    logic [31:0] imm_z;

    assign opcode = instr[31:26];
    assign rt_f   = instr[20:16];
    assign rd_f   = instr[15:11];
    assign shamt  = instr[10:6];
    assign funct  = instr[5:0];
    assign imm_s  = {{16{instr[15]}}, instr[15:0]};
    assign imm_z  = {16'h0000, instr[15:0]};

    logic [3:0]  d_op;
    logic [31:0] d_a;
    logic [31:0] d_b;
    logic [4:0]  d_rd;
    logic        d_ill;

    always_comb begin
        d_op  = OP_AND;
        d_a   = '0;
        d_b   = '0;
        d_rd  = '0;
        d_ill = 1'b1;
        case (opcode)
            OPC_SPECIAL: begin
                d_ill = 1'b0;
                d_rd  = rd_f;
                d_a   = rs_data;
                d_b   = rt_data;
                case (funct)
                    6'h24: d_op = OP_AND;
                    6'h25: d_op = OP_OR;
                    6'h26: d_op = OP_XOR;
                    6'h27: d_op = OP_NOR;
                    6'h21: d_op = OP_ADDU;
                    6'h23: d_op = OP_SUBU;
                    6'h20: d_op = OP_ADD;
                    6'h22: d_op = OP_SUB;
                    6'h2A: d_op = OP_SLT;
                    6'h2B: d_op = OP_SLTU;
                    6'h00: begin d_op = OP_SLLV; d_a = rt_data; d_b = {27'b0, shamt}; end
                    6'h02: begin d_op = OP_SRLV; d_a = rt_data; d_b = {27'b0, shamt}; end
                    6'h04: begin d_op = OP_SLLV; d_a = rt_data; d_b = {27'b0, rs_data[4:0]}; end
                    6'h06: begin d_op = OP_SRLV; d_a = rt_data; d_b = {27'b0, rs_data[4:0]}; end
                    default: begin
                        d_ill = 1'b1;
                        d_rd  = '0;
                        d_a   = '0;
                        d_b   = '0;
                    end
                endcase
            end
            OPC_SPECIAL2: begin
                if (funct == 6'h21 || funct == 6'h20) begin
                    d_ill = 1'b0;
                    d_rd  = rd_f;
                    d_a   = rs_data;
                    d_op  = (funct == 6'h21) ? OP_CLO : OP_CLZ;
                end
            end
            6'h08: begin d_ill = 1'b0; d_rd = rt_f; d_a = rs_data; d_b = imm_s; d_op = OP_ADD;  end
            6'h09: begin d_ill = 1'b0; d_rd = rt_f; d_a = rs_data; d_b = imm_s; d_op = OP_ADDU; end
            6'h0A: begin d_ill = 1'b0; d_rd = rt_f; d_a = rs_data; d_b = imm_s; d_op = OP_SLT;  end
            6'h0B: begin d_ill = 1'b0; d_rd = rt_f; d_a = rs_data; d_b = imm_s; d_op = OP_SLTU; end
            6'h0C: begin d_ill = 1'b0; d_rd = rt_f; d_a = rs_data; d_b = imm_z; d_op = OP_AND;  end
            6'h0D: begin d_ill = 1'b0; d_rd = rt_f; d_a = rs_data; d_b = imm_z; d_op = OP_OR;   end
            6'h0E: begin d_ill = 1'b0; d_rd = rt_f; d_a = rs_data; d_b = imm_z; d_op = OP_XOR;  end
            default: ;
        endcase
    end

    logic       s1_valid;
    logic [4:0] s1_rd;
    logic       s1_ill;
    logic       s2_free;
    logic       accept;

    assign s2_free  = !wb_valid || wb_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;

    // S1 drains into S2 whenever S2 is free, so a simultaneous accept simply overwrites it.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            alu_op   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            s1_rd    <= '0;
            s1_ill   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            alu_op   <= d_op;
            alu_a    <= d_a;
            alu_b    <= d_b;
            s1_rd    <= d_rd;
            s1_ill   <= d_ill;
        end else if (s2_free) begin
            s1_valid <= 1'b0;
        end
    end

    logic        is_cmp;
    logic        is_uarith;
    logic        is_sarith;
    logic        c_trap;
    logic        c_we;
    logic [31:0] c_data;
    logic [3:0]  c_flags;

    // The ALU compare ops report "not less-than", so the bit is inverted here.
    always_comb begin
        is_cmp    = (alu_op == OP_SLT) || (alu_op == OP_SLTU);
        is_uarith = (alu_op == OP_ADDU) || (alu_op == OP_SUBU);
        is_sarith = (alu_op == OP_ADD) || (alu_op == OP_SUB);
        c_trap    = TRAP_ON_OVERFLOW && is_sarith && alu_ovf && !s1_ill;
        c_we      = !s1_ill && (s1_rd != 5'd0) && !c_trap;
        c_flags   = {alu_carry & is_uarith, alu_neg & is_sarith,
                     alu_ovf & is_sarith, alu_zero & is_sarith};
        if (s1_ill)      c_data = '0;
        else if (is_cmp) c_data = {31'b0, ~alu_result[0]};
        else             c_data = alu_result;
        if (s1_ill) c_flags = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_rd       <= '0;
            wb_data     <= '0;
            wb_flags    <= '0;
            wb_illegal  <= 1'b0;
            wb_ovf_trap <= 1'b0;
        end else if (s2_free) begin
            wb_valid <= s1_valid;
            if (s1_valid) begin
                wb_we       <= c_we;
                wb_rd       <= s1_rd;
                wb_data     <= c_data;
                wb_flags    <= c_flags;
                wb_illegal  <= s1_ill;
                wb_ovf_trap <= c_trap;
            end
        end
    end

endmodule
